// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants and the camera-index FSM state type.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {
    CAM_IDLE,
    CAM_DIV,
    CAM_HOLD
  } cam_state_e;

endpackage

// File: rtl/camera_div.sv
// Sequential restoring divide by BLOCK_WIDTH, one subtraction per clock,
// with the quotient saturating at all-ones instead of wrapping.
module camera_div #(
  parameter int PHY_WIDTH   = 14,
  parameter int BLOCK_WIDTH = 480,
  parameter int CAM_WIDTH   = 5
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 start,
  input  logic [PHY_WIDTH-1:0] dividend,
  output logic                 done,
  output logic [CAM_WIDTH-1:0] quotient
);

  localparam logic [PHY_WIDTH-1:0] BW    = PHY_WIDTH'(BLOCK_WIDTH);
  localparam logic [CAM_WIDTH-1:0] Q_MAX = '1;

  logic [PHY_WIDTH-1:0] rem_q, rem_d;
  logic [CAM_WIDTH-1:0] quo_q, quo_d;
  logic                 busy_q, busy_d;
  logic                 step;

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    busy_d = busy_q;
    step   = busy_q && (rem_q >= BW) && (quo_q != Q_MAX);
    if (start) begin
      rem_d  = dividend;
      quo_d  = '0;
      busy_d = 1'b1;
    end else if (step) begin
      rem_d = rem_q - BW;
      quo_d = quo_q + 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // done is the single cycle where the busy divider can no longer subtract
  assign done     = busy_q && !step;
  assign quotient = quo_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/vga_frame_timer.sv
// VGA scan timing from the system clock plus the camera screen index, which is
// divided out during vertical blanking and committed only on the frame wrap.
module vga_frame_timer
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int SCREEN_WIDTH = 10,
  parameter int PHY_WIDTH    = 14,
  parameter int BLOCK_WIDTH  = 480,
  parameter int CAM_WIDTH    = 5,
  // Raster geometry; the defaults give the standard 640x480 raster.
  parameter int H_VIS        = H_VISIBLE,
  parameter int H_FRONT      = H_FP,
  parameter int H_PULSE      = H_SYNC,
  parameter int H_BACK       = H_BP,
  parameter int V_VIS        = V_VISIBLE,
  parameter int V_FRONT      = V_FP,
  parameter int V_PULSE      = V_SYNC,
  parameter int V_BACK       = V_BP
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [PHY_WIDTH-1:0]    char_abs_y,
  output logic                    p_tick,
  output logic [SCREEN_WIDTH-1:0] x,
  output logic [SCREEN_WIDTH-1:0] y,
  output logic                    video_on,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    frame_start,
  output logic [CAM_WIDTH-1:0]    camera_y
);

  localparam int H_TOT = H_VIS + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOT = V_VIS + V_FRONT + V_PULSE + V_BACK;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]        DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [SCREEN_WIDTH-1:0] X_LAST     = SCREEN_WIDTH'(H_TOT - 1);
  localparam logic [SCREEN_WIDTH-1:0] Y_LAST     = SCREEN_WIDTH'(V_TOT - 1);
  localparam logic [SCREEN_WIDTH-1:0] X_VIS      = SCREEN_WIDTH'(H_VIS);
  localparam logic [SCREEN_WIDTH-1:0] Y_VIS      = SCREEN_WIDTH'(V_VIS);
  localparam logic [SCREEN_WIDTH-1:0] Y_VIS_LAST = SCREEN_WIDTH'(V_VIS - 1);
  localparam logic [SCREEN_WIDTH-1:0] HS_BEG     = SCREEN_WIDTH'(H_VIS + H_FRONT);
  localparam logic [SCREEN_WIDTH-1:0] HS_END     = SCREEN_WIDTH'(H_VIS + H_FRONT + H_PULSE);
  localparam logic [SCREEN_WIDTH-1:0] VS_BEG     = SCREEN_WIDTH'(V_VIS + V_FRONT);
  localparam logic [SCREEN_WIDTH-1:0] VS_END     = SCREEN_WIDTH'(V_VIS + V_FRONT + V_PULSE);

  logic [DIV_W-1:0]        div_q, div_d;
  logic [SCREEN_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic                    tick_q, tick_d;
  logic                    vid_q, vid_d, hs_q, hs_d, vs_q, vs_d, fs_q;
  logic                    h_wrap, v_wrap, cam_latch;
  cam_state_e              state_q, state_d;
  logic [CAM_WIDTH-1:0]    cam_q, cam_d, div_quo;
  logic                    div_start, div_done;

  // Sync/blank flops decode the next counter values so they move with x/y.
  always_comb begin
    div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    tick_d    = (div_d == DIV_LAST);
    h_wrap    = tick_q && (x_q == X_LAST);
    v_wrap    = h_wrap && (y_q == Y_LAST);
    cam_latch = h_wrap && (y_q == Y_VIS_LAST);
    x_d       = x_q;
    y_d       = y_q;
    if (tick_q) x_d = h_wrap ? '0 : x_q + 1'b1;
    if (h_wrap) y_d = v_wrap ? '0 : y_q + 1'b1;
    vid_d = (x_d < X_VIS) && (y_d < Y_VIS);
    hs_d  = !((x_d >= HS_BEG) && (x_d < HS_END));
    vs_d  = !((y_d >= VS_BEG) && (y_d < VS_END));
  end

  always_comb begin
    state_d   = state_q;
    cam_d     = cam_q;
    div_start = 1'b0;
    unique case (state_q)
      CAM_IDLE: if (cam_latch) begin
        state_d   = CAM_DIV;
        div_start = 1'b1;
      end
      // A wrap before the divide finishes abandons this frame's result.
      CAM_DIV: if (v_wrap) state_d = CAM_IDLE;
               else if (div_done) state_d = CAM_HOLD;
      CAM_HOLD: if (v_wrap) begin
        state_d = CAM_IDLE;
        cam_d   = div_quo;
      end
      default: state_d = CAM_IDLE;
    endcase
  end

  camera_div #(
    .PHY_WIDTH  (PHY_WIDTH),
    .BLOCK_WIDTH(BLOCK_WIDTH),
    .CAM_WIDTH  (CAM_WIDTH)
  ) u_div (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (div_start),
    .dividend(char_abs_y),
    .done    (div_done),
    .quotient(div_quo)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      vid_q   <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
      state_q <= CAM_IDLE;
      cam_q   <= '0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vid_q   <= vid_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= v_wrap;
      state_q <= state_d;
      cam_q   <= cam_d;
    end
  end

  assign p_tick      = tick_q;
  assign x           = x_q;
  assign y           = y_q;
  assign video_on    = vid_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
  assign camera_y    = cam_q;

endmodule

// File: tb/tb_vga_frame_timer.sv
// Bench for vga_frame_timer: a full-size raster and a shrunken raster run side
// by side against an arithmetic model derived from the cycle count since reset.
module tb_vga_frame_timer;

  // index 0: standard raster, index 1: shrunken raster (frame = 29*21*2 cycles)
  localparam int M_CD  [2] = '{4, 2};
  localparam int M_HV  [2] = '{640, 20};
  localparam int M_HFP [2] = '{16, 2};
  localparam int M_HS  [2] = '{96, 4};
  localparam int M_HT  [2] = '{800, 29};
  localparam int M_VV  [2] = '{480, 12};
  localparam int M_VFP [2] = '{10, 2};
  localparam int M_VS  [2] = '{2, 2};
  localparam int M_VT  [2] = '{525, 21};

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [13:0] char_abs_y;
  logic [1:0]  pt, vo, hs, vs, fs;
  logic [1:0][9:0] xs, ys;
  logic [1:0][4:0] cs;

  always #5 sys_clk = ~sys_clk;

  vga_frame_timer u_full (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .char_abs_y(char_abs_y),
    .p_tick(pt[0]), .x(xs[0]), .y(ys[0]), .video_on(vo[0]), .hsync(hs[0]),
    .vsync(vs[0]), .frame_start(fs[0]), .camera_y(cs[0])
  );

  vga_frame_timer #(
    .CLK_DIV(2), .H_VIS(20), .H_FRONT(2), .H_PULSE(4), .H_BACK(3),
    .V_VIS(12), .V_FRONT(2), .V_PULSE(2), .V_BACK(5)
  ) u_small (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .char_abs_y(char_abs_y),
    .p_tick(pt[1]), .x(xs[1]), .y(ys[1]), .video_on(vo[1]), .hsync(hs[1]),
    .vsync(vs[1]), .frame_start(fs[1]), .camera_y(cs[1])
  );

  int n_cmp = 0, n_bad = 0, n_print = 0;

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_print < 40) $display("FAIL %s dut%0d @%0t: got %0d, want %0d", nm, d, $time, act, exp);
      n_print++;
    end
  endtask

  // Model state: edges since reset, latched dividend, committed camera index.
  int  mn [2];
  int  mlat [2];
  bit  mlv [2];
  int  mcam [2];
  bit  started = 1'b0;

  initial begin
    int p, xe, ye, pe, ve, he, vse, fe;
    forever begin
      @(negedge sys_clk);
      if (started) begin
        for (int d = 0; d < 2; d++) begin
          if (mn[d] == 0) begin
            xe = 0; ye = 0; pe = 0; ve = 0; he = 1; vse = 1; fe = 0;
          end else begin
            p   = mn[d] / M_CD[d];
            xe  = p % M_HT[d];
            ye  = (p / M_HT[d]) % M_VT[d];
            pe  = int'(mn[d] % M_CD[d] == M_CD[d] - 1);
            ve  = int'(xe < M_HV[d] && ye < M_VV[d]);
            he  = int'(!(xe >= M_HV[d] + M_HFP[d] && xe < M_HV[d] + M_HFP[d] + M_HS[d]));
            vse = int'(!(ye >= M_VV[d] + M_VFP[d] && ye < M_VV[d] + M_VFP[d] + M_VS[d]));
            fe  = int'(mn[d] % M_CD[d] == 0 && p % (M_HT[d] * M_VT[d]) == 0);
          end
          chk("x", d, int'(xs[d]), xe);
          chk("y", d, int'(ys[d]), ye);
          chk("p_tick", d, int'(pt[d]), pe);
          chk("video_on", d, int'(vo[d]), ve);
          chk("hsync", d, int'(hs[d]), he);
          chk("vsync", d, int'(vs[d]), vse);
          chk("frame_start", d, int'(fs[d]), fe);
          chk("camera_y", d, int'(cs[d]), mcam[d]);
        end
      end
      // advance the model across the coming rising edge
      for (int d = 0; d < 2; d++) begin
        if (sys_rst) begin
          mn[d] = 0; mlv[d] = 1'b0; mcam[d] = 0;
        end else begin
          p = mn[d] / M_CD[d];
          if (mn[d] % M_CD[d] == M_CD[d] - 1) begin
            xe = p % M_HT[d];
            ye = (p / M_HT[d]) % M_VT[d];
            if (xe == M_HT[d] - 1 && ye == M_VV[d] - 1) begin
              mlat[d] = int'(char_abs_y);
              mlv[d]  = 1'b1;
            end
            if (xe == M_HT[d] - 1 && ye == M_VT[d] - 1) begin
              if (mlv[d]) mcam[d] = (mlat[d] / 480 > 31) ? 31 : mlat[d] / 480;
              mlv[d] = 1'b0;
            end
          end
          mn[d]++;
        end
      end
      if (sys_rst) started = 1'b1;
    end
  end

  // Independent line/frame measurements taken straight off the outputs.
  int cyc = 0, hs_first = -1, hs_cnt = 0, vid_fall = -1;
  int w0 = -1, w1 = -1, f0 = -1, f1 = -1, px = 0;
  bit pv = 1'b0;

  initial begin
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (!hs[0] && hs_first < 0) hs_first = int'(xs[0]);
      if (!hs[0] && pt[0] && ys[0] == 10'd0) hs_cnt++;
      if (pv && !vo[0] && vid_fall < 0) vid_fall = int'(xs[0]);
      if (xs[0] == 10'd0 && px == 799) begin
        if (w0 < 0) w0 = cyc;
        else if (w1 < 0) w1 = cyc;
      end
      if (fs[1]) begin
        if (f0 < 0) f0 = cyc;
        else if (f1 < 0) f1 = cyc;
      end
      pv = vo[0];
      px = int'(xs[0]);
    end
  end

  int t;
  task automatic step_to(input int target);
    while (t < target) begin
      @(posedge sys_clk); #1;
      t++;
    end
  endtask

  initial begin
    sys_rst    = 1'b1;
    char_abs_y = 14'd1000;
    t          = 0;
    repeat (10) begin @(posedge sys_clk); #1; end
    chk("rst_x", 0, int'(xs[0]), 0);
    chk("rst_video_on", 0, int'(vo[0]), 0);
    chk("rst_hsync", 0, int'(hs[0]), 1);
    chk("rst_camera_y", 1, int'(cs[1]), 0);
    sys_rst = 1'b0;
    t = 0;

    step_to(1);
    chk("rel_video_on", 0, int'(vo[0]), 1);
    chk("rel_x", 0, int'(xs[0]), 0);
    chk("rel_y", 0, int'(ys[0]), 0);
    chk("rel_p_tick", 0, int'(pt[0]), 0);
    step_to(3);
    chk("first_p_tick", 0, int'(pt[0]), 1);

    step_to(1217);
    chk("cam_before_wrap", 1, int'(cs[1]), 0);
    step_to(1218);
    chk("wrap_frame_start", 1, int'(fs[1]), 1);
    chk("cam_1000", 1, int'(cs[1]), 2);
    chk("wrap_x", 1, int'(xs[1]), 0);
    chk("wrap_y", 1, int'(ys[1]), 0);

    step_to(1300); char_abs_y = 14'd479;
    step_to(2436); chk("cam_479", 1, int'(cs[1]), 0);
    step_to(2500); char_abs_y = 14'd16000;
    step_to(3400); char_abs_y = 14'd0;
    step_to(3654); chk("cam_saturate", 1, int'(cs[1]), 31);
    step_to(4872); chk("cam_late_zero", 1, int'(cs[1]), 0);
    step_to(5000); char_abs_y = 14'd1500;
    step_to(6090); chk("cam_1500", 1, int'(cs[1]), 3);
    step_to(6100); char_abs_y = 14'd2000;

    step_to(6500);
    chk("hsync_low_ticks", 0, hs_cnt, 96);
    chk("hsync_first_x", 0, hs_first, 656);
    chk("video_fall_x", 0, vid_fall, 640);
    chk("line_period", 0, w1 - w0, 3200);
    chk("small_frame_period", 1, f1 - f0, 1218);

    // reset lands two edges into the divide of the 2000 dividend
    step_to(6787); sys_rst = 1'b1;
    step_to(6788);
    chk("mid_div_rst_cam", 1, int'(cs[1]), 0);
    chk("mid_div_rst_x", 1, int'(xs[1]), 0);
    chk("mid_div_rst_y", 1, int'(ys[1]), 0);
    chk("mid_div_rst_video", 0, int'(vo[0]), 0);
    sys_rst = 1'b0;
    t = 0;
    step_to(1217); chk("cam_after_rst_hold", 1, int'(cs[1]), 0);
    step_to(1218); chk("cam_2000", 1, int'(cs[1]), 4);

    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(20, 400)) begin @(posedge sys_clk); #1; end
      case ($urandom_range(0, 9))
        0: begin
          sys_rst = 1'b1;
          repeat ($urandom_range(1, 3)) begin @(posedge sys_clk); #1; end
          sys_rst = 1'b0;
        end
        1: char_abs_y = 14'h3fff;
        2: char_abs_y = 14'($urandom_range(1, 33) * 480 - $urandom_range(0, 1));
        default: char_abs_y = 14'($urandom_range(0, 16383));
      endcase
    end
    repeat (20) begin @(posedge sys_clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
